// File: rtl/ql_kbd_pkg.sv
// ----------------------------------------------------------------------------
// ql_kbd_pkg
// Shared definitions for the QL keyboard scanner:
//   - scanner FSM state encoding (IDLE / SNAP / ROW)
//   - event byte field positions: {pressed, 0, row[2:0], col[2:0]}
//   - matrix geometry (8 rows x 8 columns)
//   - priority_col(): index of the lowest set bit of a row byte
// ----------------------------------------------------------------------------
package ql_kbd_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SNAP = 2'd1;
    localparam logic [1:0] ST_ROW  = 2'd2;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    localparam int EV_PRESSED = 7;
    localparam int EV_ROW_HI  = 5;
    localparam int EV_ROW_LO  = 3;
    localparam int EV_COL_HI  = 2;
    localparam int EV_COL_LO  = 0;

    // Lowest set bit wins; scanning downwards lets the last hit be the lowest.
    // Returns 0 for an all-zero byte (callers only use it when diff != 0).
    function automatic logic [2:0] priority_col(input logic [7:0] b);
        logic [2:0] idx;
        idx = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (b[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// ----------------------------------------------------------------------------
// kbd_event_fifo
// Small synchronous FIFO holding keyboard make/break events.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (empties the FIFO)
//   push_i      : write data_i (ignored while full_o)
//   data_i      : event byte to write
//   pop_i       : drop the head entry (ignored while empty_o)
//   full_o      : count == DEPTH
//   empty_o     : count == 0
//   head_o      : oldest entry, forced to 0 while empty
// ----------------------------------------------------------------------------
module kbd_event_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    // Flags come straight from the registered count, so a pop in the same
    // cycle never frees a slot for a push.
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Gate the head so stale RAM contents never show up on an empty FIFO.
    assign head_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/ql_kbd_scanner.sv
// ----------------------------------------------------------------------------
// ql_kbd_scanner
// Walks the 64-bit QL key matrix row by row on each scan tick and queues one
// make/break event per changed key for the IPC emulation.
// Ports:
//   clk, reset : 11 MHz clock, synchronous active-high reset
//   matrix     : key matrix, bit 8*row+col set = key down
//   scan_tick  : one-cycle pulse starting a pass (ignored while busy)
//   ev_valid   : event FIFO holds an entry
//   ev_data    : FIFO head {pressed, 0, row[2:0], col[2:0]}
//   ev_ready   : consumer pops the head when ev_valid & ev_ready
//   busy       : scan pass in progress
//   any_key    : registered OR of the stored key state
//   overflow   : sticky, an event was held back by a full FIFO
//   ovf_clr    : clears overflow (a same-cycle set wins)
// ----------------------------------------------------------------------------
module ql_kbd_scanner
    import ql_kbd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] matrix,
    input  logic        scan_tick,
    output logic        ev_valid,
    output logic [7:0]  ev_data,
    input  logic        ev_ready,
    output logic        busy,
    output logic        any_key,
    output logic        overflow,
    input  logic        ovf_clr
);

    logic [1:0]  state_q, state_d;
    logic [2:0]  row_q, row_d;
    logic [63:0] snap_q;
    logic [63:0] stored_q, stored_d;
    logic        busy_q, busy_d;
    logic        any_key_q;
    logic        overflow_q, overflow_d;

    logic [7:0]  snap_row   [ROWS];
    logic [7:0]  stored_row [ROWS];
    logic [7:0]  diff;
    logic [2:0]  col;
    logic        key_bit;
    logic        ovf_set;
    logic        push;
    logic [7:0]  ev_word;
    logic        fifo_full;
    logic        fifo_empty;

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_rows
        assign snap_row[gi]   = snap_q[gi*COLS +: COLS];
        assign stored_row[gi] = stored_q[gi*COLS +: COLS];
    end

    assign diff    = snap_row[row_q] ^ stored_row[row_q];
    assign col     = priority_col(diff);
    assign key_bit = snap_row[row_q][col];

    always_comb begin
        ev_word                        = '0;
        ev_word[EV_PRESSED]            = key_bit;
        ev_word[EV_ROW_HI:EV_ROW_LO]   = row_q;
        ev_word[EV_COL_HI:EV_COL_LO]   = col;
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        stored_d = stored_q;
        busy_d   = busy_q;
        ovf_set  = 1'b0;
        push     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (scan_tick) begin
                    state_d = ST_SNAP;
                    busy_d  = 1'b1;
                end
            end
            ST_SNAP: begin
                row_d   = '0;
                busy_d  = 1'b1;
                state_d = ST_ROW;
            end
            ST_ROW: begin
                if (diff == '0) begin
                    if (row_q == 3'd7) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else if (!fifo_full) begin
                    // Stay on this row: the next cycle sees the next-lowest change.
                    push                     = 1'b1;
                    stored_d[{row_q, col}]   = key_bit;
                end else begin
                    // Remaining changes stay unrecorded and reappear next pass.
                    ovf_set = 1'b1;
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign overflow_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            snap_q     <= '0;
            stored_q   <= '0;
            busy_q     <= 1'b0;
            any_key_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            stored_q   <= stored_d;
            busy_q     <= busy_d;
            any_key_q  <= |stored_q;
            overflow_q <= overflow_d;
            if (state_q == ST_SNAP) snap_q <= matrix;
        end
    end

    kbd_event_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (ev_word),
        .pop_i   (ev_ready),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (ev_data)
    );

    assign ev_valid = ~fifo_empty;
    assign busy     = busy_q;
    assign any_key  = any_key_q;
    assign overflow = overflow_q;

endmodule
